// File: rtl/fr_add_norm.sv
// fr_add_norm: mantissa add/subtract and iterative normalize stage of the FP MAC.
//   clock, reset           rising-edge clock, synchronous active-high reset
//   in_valid / in_ready    operand handshake (in_ready high only when idle)
//   man_big, man_small     larger-exponent mantissa and aligned smaller mantissa
//   sign_big, sign_small   operand signs; exp_big is the larger biased exponent
//   out_valid              one-cycle result pulse
//   out_sign/exp/man       normalized truncated result (hidden bit removed)
//   out_zero, out_ovf      exact cancel / underflow flush, exponent overflow
module fr_add_norm #(
    parameter int MW = 24,
    parameter int EW = 8
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [MW-1:0] man_big,
    input  logic [MW-1:0] man_small,
    input  logic          sign_big,
    input  logic          sign_small,
    input  logic [EW-1:0] exp_big,
    output logic          out_valid,
    output logic          out_sign,
    output logic [EW-1:0] out_exp,
    output logic [MW-2:0] out_man,
    output logic          out_zero,
    output logic          out_ovf
);
    typedef enum logic [1:0] {IDLE, ADD, NORM, DONE} state_t;
    localparam logic [EW:0] EMAX = {1'b0, {EW{1'b1}}};
    state_t state, state_nx;
    logic [MW-1:0] mb, ms;
    logic sb, ss, sgn;
    logic [EW-1:0] eb, e;
    logic [MW:0] sum;
    logic [EW:0] e_inc;
    logic is_zero, carry, hid, finish, res_zero, res_ovf, res_sign;
    logic [EW-1:0] res_exp;
    logic [MW-2:0] res_man;
    always_comb begin
        is_zero  = sum == '0;
        carry    = sum[MW];
        hid      = sum[MW-1];
        e_inc    = {1'b0, e} + 1'b1;
        // Normalization stops on zero, carry, hidden bit present, or when a further
        // left shift would push the exponent below the smallest normal value.
        finish   = is_zero | carry | hid | (e <= EW'(1));
        res_zero = is_zero | (!carry & !hid);
        res_ovf  = !is_zero & carry & (e_inc >= EMAX);
        res_sign = res_zero ? 1'b0 : sgn;
        res_exp  = res_zero ? '0 : res_ovf ? EMAX[EW-1:0] : carry ? e_inc[EW-1:0] : e;
        res_man  = (res_zero | res_ovf) ? '0 : carry ? sum[MW-1:1] : sum[MW-2:0];
        state_nx = state == IDLE ? (in_valid ? ADD : IDLE) :
                   state == ADD  ? NORM :
                   state == NORM ? (finish ? DONE : NORM) : IDLE;
    end
    assign in_ready  = state == IDLE;
    assign out_valid = state == DONE;
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            mb       <= '0;
            ms       <= '0;
            sb       <= 1'b0;
            ss       <= 1'b0;
            eb       <= '0;
            e        <= '0;
            sum      <= '0;
            sgn      <= 1'b0;
            out_sign <= 1'b0;
            out_exp  <= '0;
            out_man  <= '0;
            out_zero <= 1'b0;
            out_ovf  <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: if (in_valid) begin
                    mb <= man_big;
                    ms <= man_small;
                    sb <= sign_big;
                    ss <= sign_small;
                    eb <= exp_big;
                end
                ADD: begin
                    e <= eb;
                    // Reversed magnitude only arises with equal exponents; the
                    // result then takes the smaller-exponent operand's sign.
                    if (sb == ss) begin
                        sum <= {1'b0, mb} + {1'b0, ms};
                        sgn <= sb;
                    end else if (mb >= ms) begin
                        sum <= {1'b0, mb} - {1'b0, ms};
                        sgn <= sb;
                    end else begin
                        sum <= {1'b0, ms} - {1'b0, mb};
                        sgn <= ss;
                    end
                end
                NORM: if (finish) begin
                    out_sign <= res_sign;
                    out_exp  <= res_exp;
                    out_man  <= res_man;
                    out_zero <= res_zero;
                    out_ovf  <= res_ovf;
                end else begin
                    sum <= sum << 1;
                    e   <= e - 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/fr_add_norm.md
Name: fr_add_norm

Overview:
- Mantissa add/subtract and normalize stage of the floating-point MAC.
- Sits directly downstream of the mantissa alignment shifter. It consumes the unshifted larger-exponent mantissa, the right-shifted smaller-exponent mantissa, both signs and the larger exponent.
- Produces a normalized IEEE-754 single-precision sign/exponent/fraction. Result is truncated (no rounding) and denormals are flushed to zero.
- Multi-cycle: leading-zero normalization is iterative, one left shift per clock, under a small FSM with a valid/ready handshake.

Parameters:
- MW, 24, mantissa width including hidden bit.
- EW, 8, exponent width.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  input operands valid.
- in_ready  output  1  block can accept operands (high only in IDLE).
- man_big  input  MW  mantissa of the larger-exponent operand, hidden bit at [MW-1].
- man_small  input  MW  aligned (right-shifted) mantissa of the other operand.
- sign_big  input  1  sign of the man_big operand.
- sign_small  input  1  sign of the man_small operand.
- exp_big  input  EW  larger biased exponent.
- out_valid  output  1  one-cycle pulse, result valid.
- out_sign  output  1  result sign.
- out_exp  output  EW  result biased exponent.
- out_man  output  MW-1  result fraction (hidden bit removed).
- out_zero  output  1  result is zero (exact cancel or underflow flush).
- out_ovf  output  1  exponent overflow; result is infinity.

Behaviour:
- Reset (synchronous, highest priority): state=IDLE; all outputs 0 except in_ready=1; internal registers cleared. Reset during any state aborts the in-flight operation; nothing is emitted.
- States: IDLE, ADD, NORM, DONE.
- IDLE: in_ready=1. On in_valid=1, latch all inputs, go to ADD. in_valid outside IDLE is ignored (in_ready=0).
- ADD (1 cycle): eff_sub = sign_big ^ sign_small.
  - eff_sub=0: sum (MW+1 bits) = man_big + man_small; sign = sign_big.
  - eff_sub=1 and man_big >= man_small: sum = man_big - man_small; sign = sign_big.
  - eff_sub=1 and man_big < man_small (only possible with equal exponents): sum = man_small - man_big; sign = sign_small.
  - Working exponent e = exp_big. Go to NORM.
- NORM, evaluated each cycle in priority order:
  - sum==0: zero result, out_zero=1, sign 0, exp 0, man 0 → DONE.
  - sum[MW]=1: sum >>= 1, e+1.
    - If e+1 >= 2^EW-1: out_ovf=1, exp = 2^EW-1, man 0 → DONE.
    - Otherwise: result = sum[MW-2:0] after the shift, exp = e+1 → DONE.
  - sum[MW-1]=1: result = sum[MW-2:0], exp = e → DONE.
  - Otherwise, if e <= 1: underflow flush, out_zero=1, sign 0, exp 0, man 0 → DONE.
  - Otherwise: sum <<= 1, e−1, stay in NORM.
- Output registers (out_sign/out_exp/out_man/out_zero/out_ovf) load on the NORM → DONE transition. They hold until the next result loads or reset.
- DONE: out_valid=1 for exactly this cycle, then go to IDLE.
- Latency: operands accepted in cycle N gives out_valid in cycle N+3+k, where k = number of left shifts (0..MW-1). Back-to-back throughput is one result per 4+k cycles.
- Zero input (exp_big=0 with both mantissas 0) follows the sum==0 path and gives out_zero=1.
- Truncation only; bits shifted out on carry normalization are discarded.

Test Plan:
- 1.0+1.0: man_big=man_small=0x800000, exp_big=127, signs 0 → out_exp=128, out_man=0, sign 0, out_valid at N+3.
- 1.5−1.0: man_big=0xC00000 sign 0, man_small=0x800000 sign 1, exp 127 → one left shift, out_exp=126, out_man=0, sign 0, out_valid at N+4.
- Reversed magnitude: man_big=0x800000 sign 0, man_small=0xC00000 sign 1, exp 127 → out_sign=1, out_exp=126, out_man=0.
- Exact cancel: 0xA00000 vs 0xA00000, opposite signs, exp 100 → out_zero=1, exp 0, man 0, sign 0, out_valid at N+3.
- Overflow: exp_big=254, both 0xFFFFFF, signs 0 → out_ovf=1, out_exp=255, out_man=0.
- Control: with man_big=0x800000, man_small=0x7FFFFF, opposite signs, exp 30, pulse in_valid during NORM and check it is ignored (in_ready=0). Also assert reset in NORM mid-shift and check no out_valid, IDLE next cycle, outputs zero. Finally, exp 5 with the same mantissas must underflow-flush with out_zero=1.
